hazard_ctrl: RTL and testbench

//  Hazard controller for the 5-stage scalar pipeline. It drives the CLR of the decode->execute

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage scalar pipeline.
// Resolves RAW hazards by forwarding, inserts a bubble for load-use hazards,
// holds the execute stage while a multi-cycle ALU op completes, and counts
// stall cycles for performance debug.
// There is no valid/ready handshake in this block. Every control output is a
// same-cycle decode of the current FSM state and the pipeline inputs.
module hazard_ctrl #(
  parameter int                    ALU_CTRL_W = 4,
  parameter logic [ALU_CTRL_W-1:0] MULTI_OP   = 4'b1010,
  parameter int                    MULTI_LAT  = 4,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4:0]            RA1_D,
  input  logic [4:0]            RA2_D,
  input  logic [4:0]            RA1_E,
  input  logic [4:0]            RA2_E,
  input  logic [4:0]            WRITE_REG_E,
  input  logic                  REG_WRITE_E,
  input  logic                  MEM_TO_REG_E,
  input  logic [ALU_CTRL_W-1:0] ALU_CONTROL_E,
  input  logic [4:0]            WRITE_REG_M,
  input  logic                  REG_WRITE_M,
  input  logic [4:0]            WRITE_REG_W,
  input  logic                  REG_WRITE_W,
  output logic                  STALL_F,
  output logic                  STALL_D,
  output logic                  STALL_E,
  output logic                  FLUSH_E,
  output logic                  FLUSH_M,
  output logic [1:0]            FWD_A_E,
  output logic [1:0]            FWD_B_E,
  output logic [CNT_WIDTH-1:0]  STALL_COUNT,
  output logic [1:0]            DBG_STATE
);

  // The counter only ever holds values up to MULTI_LAT-2.
  localparam int           CW       = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_LAT - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         fsm;
  logic [CW-1:0]  cnt;
  logic           is_multi;
  logic           multi_stall;
  logic           lu;

  // Operand source select: M stage beats W stage, r0 never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       wr_m,
    input logic [4:0] reg_m,
    input logic       wr_w,
    input logic [4:0] reg_w
  );
    if (src == 5'd0)                  return 2'b00;
    else if (wr_m && (reg_m == src))  return 2'b10;
    else if (wr_w && (reg_w == src))  return 2'b01;
    else                              return 2'b00;
  endfunction

  assign is_multi    = (ALU_CONTROL_E == MULTI_OP);
  // In DONE the completing op is still in E, so is_multi must not restart a stall.
  assign multi_stall = ((fsm == IDLE) && is_multi) || (fsm == BUSY);
  assign lu          = MEM_TO_REG_E && REG_WRITE_E && (WRITE_REG_E != 5'd0) &&
                       ((WRITE_REG_E == RA1_D) || (WRITE_REG_E == RA2_D));
  assign DBG_STATE   = fsm;

  // Multi-cycle execute FSM: IDLE stalls the first cycle, BUSY counts down the rest.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm <= IDLE;
      cnt <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (is_multi) begin
            cnt <= CNT_LOAD;
            if (MULTI_LAT > 2) fsm <= BUSY;
            else               fsm <= DONE;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) fsm <= DONE;
        end
        DONE: fsm <= IDLE;
        default: begin
          fsm <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

  // Stall, flush and forward decode; multi-cycle stall overrides load-use.
  always_comb begin
    STALL_F = 1'b0;
    STALL_D = 1'b0;
    STALL_E = 1'b0;
    FLUSH_E = 1'b0;
    FLUSH_M = 1'b0;
    FWD_A_E = 2'b00;
    FWD_B_E = 2'b00;
    if (RST) begin
      FLUSH_E = 1'b1;
      FLUSH_M = 1'b1;
    end else begin
      FWD_A_E = fwd_sel(RA1_E, REG_WRITE_M, WRITE_REG_M, REG_WRITE_W, WRITE_REG_W);
      FWD_B_E = fwd_sel(RA2_E, REG_WRITE_M, WRITE_REG_M, REG_WRITE_W, WRITE_REG_W);
      if (multi_stall) begin
        STALL_F = 1'b1;
        STALL_D = 1'b1;
        STALL_E = 1'b1;
        FLUSH_M = 1'b1;
      end else if (lu) begin
        STALL_F = 1'b1;
        STALL_D = 1'b1;
        FLUSH_E = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which decode is held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_COUNT <= '0;
    end else if (STALL_D && (STALL_COUNT != {CNT_WIDTH{1'b1}})) begin
      STALL_COUNT <= STALL_COUNT + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, load-use, multi-cycle
// execute, combined hazards, reset mid-op and stall counter saturation.
module tb_hazard_ctrl;

  localparam logic [3:0] MULTI = 4'b1010;
  // Control vector layout: {STALL_F, STALL_D, STALL_E, FLUSH_E, FLUSH_M}
  localparam logic [4:0] V_NONE = 5'b00000;
  localparam logic [4:0] V_MULT = 5'b11101;
  localparam logic [4:0] V_LU   = 5'b11010;
  localparam logic [4:0] V_RST  = 5'b00011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0]  ra1_d, ra2_d, ra1_e, ra2_e, write_reg_e, write_reg_m, write_reg_w;
  logic        reg_write_e, mem_to_reg_e, reg_write_m, reg_write_w;
  logic [3:0]  alu_control_e;
  logic        stall_f, stall_d, stall_e, flush_e, flush_m;
  logic [1:0]  fwd_a_e, fwd_b_e, dbg_state;
  logic [31:0] stall_count;
  logic [4:0]  ctrl;

  // saturation instance signals
  logic        sat_lu;
  logic        s_stall_f, s_stall_d, s_stall_e, s_flush_e, s_flush_m;
  logic [1:0]  s_fwd_a, s_fwd_b, s_dbg;
  logic [3:0]  s_count;

  assign ctrl = {stall_f, stall_d, stall_e, flush_e, flush_m};

  hazard_ctrl #(.ALU_CTRL_W(4), .MULTI_OP(MULTI), .MULTI_LAT(4), .CNT_WIDTH(32)) u_dut (
    .CLK(clk), .RST(rst),
    .RA1_D(ra1_d), .RA2_D(ra2_d), .RA1_E(ra1_e), .RA2_E(ra2_e),
    .WRITE_REG_E(write_reg_e), .REG_WRITE_E(reg_write_e), .MEM_TO_REG_E(mem_to_reg_e),
    .ALU_CONTROL_E(alu_control_e),
    .WRITE_REG_M(write_reg_m), .REG_WRITE_M(reg_write_m),
    .WRITE_REG_W(write_reg_w), .REG_WRITE_W(reg_write_w),
    .STALL_F(stall_f), .STALL_D(stall_d), .STALL_E(stall_e),
    .FLUSH_E(flush_e), .FLUSH_M(flush_m),
    .FWD_A_E(fwd_a_e), .FWD_B_E(fwd_b_e),
    .STALL_COUNT(stall_count), .DBG_STATE(dbg_state)
  );

  // Narrow-counter instance driven by a permanent load-use pattern on sat_lu.
  hazard_ctrl #(.ALU_CTRL_W(4), .MULTI_OP(MULTI), .MULTI_LAT(4), .CNT_WIDTH(4)) u_sat (
    .CLK(clk), .RST(rst),
    .RA1_D(5'd3), .RA2_D(5'd0), .RA1_E(5'd0), .RA2_E(5'd0),
    .WRITE_REG_E(5'd3), .REG_WRITE_E(sat_lu), .MEM_TO_REG_E(sat_lu),
    .ALU_CONTROL_E(4'd0),
    .WRITE_REG_M(5'd0), .REG_WRITE_M(1'b0),
    .WRITE_REG_W(5'd0), .REG_WRITE_W(1'b0),
    .STALL_F(s_stall_f), .STALL_D(s_stall_d), .STALL_E(s_stall_e),
    .FLUSH_E(s_flush_e), .FLUSH_M(s_flush_m),
    .FWD_A_E(s_fwd_a), .FWD_B_E(s_fwd_b),
    .STALL_COUNT(s_count), .DBG_STATE(s_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_cnt  = 0;
  logic [4:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Checks one cycle's control vector and running stall count, then advances the model.
  task automatic expect_cycle(input string tag, input logic [4:0] vec);
    #1;
    check({tag, "_ctrl"}, {27'd0, ctrl}, {27'd0, vec});
    check({tag, "_cnt"}, stall_count, exp_cnt);
    if (rst) exp_cnt = 0;
    else if (vec[3]) exp_cnt = exp_cnt + 1;
  endtask

  // Runs queued expectations, one per cycle, with inputs held.
  task automatic run_q(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      expect_cycle(tag, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ra1_d = 0; ra2_d = 0; ra1_e = 0; ra2_e = 0;
    write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0; alu_control_e = 0;
    write_reg_m = 0; reg_write_m = 0; write_reg_w = 0; reg_write_w = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = rd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    sat_lu = 0;
    rst = 1;
    repeat (2) @(posedge clk);

    // reset state: forced outputs, counters cleared
    @(negedge clk);
    expect_cycle("reset", V_RST);
    check("reset_fwd", {30'd0, fwd_a_e}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);

    // 1. forwarding
    @(negedge clk);
    rst = 0;
    ra1_e = 5; ra2_e = 9;
    reg_write_m = 1; write_reg_m = 5;
    reg_write_w = 1; write_reg_w = 5;
    expect_cycle("fwd_mw", V_NONE);
    check("fwd_a_m_prio", {30'd0, fwd_a_e}, 32'd2);
    check("fwd_b_none", {30'd0, fwd_b_e}, 32'd0);

    @(negedge clk);
    reg_write_m = 0;
    ra2_e = 5;
    expect_cycle("fwd_w", V_NONE);
    check("fwd_a_w", {30'd0, fwd_a_e}, 32'd1);
    check("fwd_b_w", {30'd0, fwd_b_e}, 32'd1);

    @(negedge clk);
    ra1_e = 0; ra2_e = 12;
    reg_write_m = 1; write_reg_m = 0;
    reg_write_w = 1; write_reg_w = 12;
    expect_cycle("fwd_r0", V_NONE);
    check("fwd_a_r0", {30'd0, fwd_a_e}, 32'd0);
    check("fwd_b_w12", {30'd0, fwd_b_e}, 32'd1);

    // 2. load-use: one bubble, then the pipe proceeds
    @(negedge clk);
    clear_inputs();
    set_load_use(7); ra2_d = 7;
    expect_cycle("lu_stall", V_LU);
    @(negedge clk);
    clear_inputs();
    expect_cycle("lu_release", V_NONE);
    check("lu_count_is_1", stall_count, 32'd1);

    // load to r0 is never a hazard
    @(negedge clk);
    set_load_use(0); ra1_d = 0;
    expect_cycle("lu_r0", V_NONE);

    // 3. single multi-cycle op held in E
    @(negedge clk);
    clear_inputs();
    alu_control_e = MULTI;
    expect_cycle("multi_idle", V_MULT);
    check("multi_st_idle", {30'd0, dbg_state}, 32'd0);
    exp_q.push_back(V_MULT); exp_q.push_back(V_MULT); exp_q.push_back(V_NONE);
    run_q("multi");
    check("multi_st_done", {30'd0, dbg_state}, 32'd2);
    @(negedge clk);
    alu_control_e = 0;
    expect_cycle("multi_after", V_NONE);
    check("multi_st_back", {30'd0, dbg_state}, 32'd0);

    // 4. back-to-back multi-cycle ops
    @(negedge clk);
    alu_control_e = MULTI;
    expect_cycle("b2b_0", V_MULT);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(V_MULT); exp_q.push_back(V_MULT); exp_q.push_back(V_NONE);
      if (k == 0) exp_q.push_back(V_MULT);
    end
    run_q("b2b");
    @(negedge clk);
    alu_control_e = 0;
    expect_cycle("b2b_after", V_NONE);

    // 5. multi op plus load-use: multi stall wins, load-use flush on DONE only
    @(negedge clk);
    alu_control_e = MULTI;
    set_load_use(7); ra1_d = 7;
    expect_cycle("mix_0", V_MULT);
    exp_q.push_back(V_MULT); exp_q.push_back(V_MULT); exp_q.push_back(V_LU);
    run_q("mix");
    @(negedge clk);
    clear_inputs();
    expect_cycle("mix_after", V_NONE);

    // 6. reset during the second BUSY cycle
    @(negedge clk);
    alu_control_e = MULTI;
    expect_cycle("rmid_idle", V_MULT);
    @(negedge clk);
    expect_cycle("rmid_busy1", V_MULT);
    @(negedge clk);
    rst = 1;
    expect_cycle("rmid_rst", V_RST);
    check("rmid_fwd", {30'd0, fwd_b_e}, 32'd0);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    expect_cycle("rmid_after", V_NONE);
    check("rmid_state", {30'd0, dbg_state}, 32'd0);
    check("rmid_cnt0", stall_count, 32'd0);

    // saturation of a 4-bit stall counter over 20 stall cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sat_lu = 1;
      #1;
      check("sat_stall", {31'd0, s_stall_d}, 32'd1);
      check("sat_cnt", {28'd0, s_count}, (i > 15) ? 32'd15 : 32'(i));
    end
    @(negedge clk);
    sat_lu = 0;
    #1;
    check("sat_final", {28'd0, s_count}, 32'd15);
    check("sat_released", {31'd0, s_stall_d}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
